// File: rtl/chip_pkg.sv
// Shared types and constants for the output pad scheduler.
package chip_pkg;

    // Frame sequencing states of the pad scheduler.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } pad_sched_state_t;

    // Default width of the output pad bus (strobe plus data).
    localparam int DEFAULT_NUM_OUTPUT_PADS = 10;

    // Bit of the pad bus that carries the strobe for the default bus width.
    localparam int STROBE_BIT = DEFAULT_NUM_OUTPUT_PADS - 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      grant_idx_o,
    output logic               any_grant_o
);

    logic [IW-1:0] cand;

    // Pick the first requester after the previous winner; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IW'((int'(last_grant_i) + off) % NUM_REQ);
            if (!any_grant_o && req_i[cand]) begin
                any_grant_o   = 1'b1;
                grant_idx_o   = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_out_scheduler.sv
// Shares the output pad bus between requesters, sending each word as a
// setup / strobe / hold frame. A synchronised halt pauses new grants.
module pad_out_scheduler
    import chip_pkg::*;
#(
    parameter int NUM_OUTPUT_PADS = DEFAULT_NUM_OUTPUT_PADS,
    parameter int NUM_REQ         = 4,
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*(NUM_OUTPUT_PADS-1)-1:0] req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic                                   halt_in,
    output logic [NUM_OUTPUT_PADS-1:0]             output_out,
    output logic                                   busy,
    output logic [$clog2(NUM_REQ)-1:0]             grant_id
);

    localparam int DW      = NUM_OUTPUT_PADS - 1;
    localparam int IW      = $clog2(NUM_REQ);
    localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    pad_sched_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic             halt_meta_q, halt_s_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [DW-1:0]      win_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_grant_o  (arb_any)
    );

    // Two-flop synchroniser for the asynchronous halt pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_meta_q <= 1'b0;
            halt_s_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so both flops sample the pre-edge values.
            halt_meta_q <= halt_in;
            halt_s_q    <= halt_meta_q;
        end
    end

    // Select the winning requester's word from the packed data bus.
    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) win_word = req_data[i*DW +: DW];
        end
    end

    // Frame state, phase counter, captured word and grant pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    // Next-state logic: grant in IDLE, then count through setup, strobe and hold.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        req_ready    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any && !halt_s_q) begin
                    req_ready    = arb_grant;
                    data_d       = win_word;
                    last_grant_d = arb_idx;
                    grant_id_d   = arb_idx;
                    cnt_d        = CW'(SETUP_CYCLES - 1);
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(STROBE_CYCLES - 1);
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign output_out = {state_q == ST_STROBE, data_q};
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_id_q;

endmodule
